// File: rtl/freq_div_duty_if.sv
// Configuration and divided-clock bus of the programmable divider.
// The master drives enable, load strobe and the requested divide/high
// values; the slave (the divider) returns the divided clock and status.
interface freq_div_duty_if #(
    parameter int W = 8
);
    logic         i_en;
    logic [W-1:0] i_div;
    logic [W-1:0] i_high;
    logic         i_load;
    logic         o_clk_div;
    logic         o_period_start;
    logic         o_cfg_pending;
    logic         o_cfg_err;

    modport master (
        output i_en, i_div, i_high, i_load,
        input  o_clk_div, o_period_start, o_cfg_pending, o_cfg_err
    );

    modport slave (
        input  i_en, i_div, i_high, i_load,
        output o_clk_div, o_period_start, o_cfg_pending, o_cfg_err
    );
endinterface

// File: rtl/freq_div_duty.sv
// Programmable clock divider with configurable duty cycle.
// A new divide/high pair is validated at load time, parked in a pending
// slot and only promoted to the active slot on a period boundary, so the
// divided clock never produces a runt pulse.
module freq_div_duty #(
    parameter int W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    freq_div_duty_if.slave   bus
);

    logic [W-1:0] cnt_q,    cnt_d;
    logic [W-1:0] div_a_q,  div_a_d;
    logic [W-1:0] high_a_q, high_a_d;
    logic [W-1:0] div_p_q,  div_p_d;
    logic [W-1:0] high_p_q, high_p_d;
    logic         clk_div_q, clk_div_d;
    logic         pstart_q,  pstart_d;
    logic         pending_q, pending_d;
    logic         err_q,     err_d;

    // Counter increment carried in W+1 bits so div = 2^W-1 cannot overflow.
    logic [W:0]   cnt_inc;
    logic         wrap;
    logic         load_legal;

    // Next-state logic: counting, boundary promotion, and load validation.
    always_comb begin
        cnt_d      = cnt_q;
        div_a_d    = div_a_q;
        high_a_d   = high_a_q;
        div_p_d    = div_p_q;
        high_p_d   = high_p_q;
        clk_div_d  = clk_div_q;
        pstart_d   = 1'b0;
        pending_d  = pending_q;
        err_d      = err_q;

        cnt_inc    = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        // cnt + 1 >= div is cnt >= div - 1 without any underflow risk; the
        // >= also pulls an out-of-range count back to a boundary.
        wrap       = (cnt_inc >= {1'b0, div_a_q});
        load_legal = (bus.i_div >= W'(2)) && (bus.i_high >= W'(1)) &&
                     (bus.i_high < bus.i_div);

        if (bus.i_en) begin
            if (wrap) begin
                cnt_d     = '0;
                clk_div_d = 1'b1;
                pstart_d  = 1'b1;
                if (pending_q) begin
                    div_a_d   = div_p_q;
                    high_a_d  = high_p_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d     = cnt_inc[W-1:0];
                clk_div_d = (cnt_inc < {1'b0, high_a_q});
            end
        end

        // A load on a wrap edge lands after the promotion above, so the old
        // pending value is applied now and the new one waits for the next
        // boundary.
        if (bus.i_load) begin
            if (load_legal) begin
                div_p_d   = bus.i_div;
                high_p_d  = bus.i_high;
                pending_d = 1'b1;
                err_d     = 1'b0;
            end else begin
                err_d     = 1'b1;
            end
        end
    end

    // State registers; reset restores divide-by-2 at 50% and drops any pending config.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= W'(1);
            div_a_q   <= W'(2);
            high_a_q  <= W'(1);
            div_p_q   <= W'(2);
            high_p_q  <= W'(1);
            clk_div_q <= 1'b0;
            pstart_q  <= 1'b0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_a_q   <= div_a_d;
            high_a_q  <= high_a_d;
            div_p_q   <= div_p_d;
            high_p_q  <= high_p_d;
            clk_div_q <= clk_div_d;
            pstart_q  <= pstart_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_clk_div      = clk_div_q;
    assign bus.o_period_start = pstart_q;
    assign bus.o_cfg_pending  = pending_q;
    assign bus.o_cfg_err      = err_q;

endmodule

// File: tb/tb_freq_div_duty.sv
// Bench for freq_div_duty: directed scenarios plus random enable/load
// traffic, checked every cycle against a waveform-queue reference model.
module tb_freq_div_duty;

    localparam int W = 8;

    logic i_clk;
    logic i_rst_n;

    freq_div_duty_if #(.W(W)) bus ();

    freq_div_duty #(.W(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the current period is a queue of output levels,
    // built as high ones followed by div-high zeros when a period starts.
    int   m_wave[$];
    int   m_div_a, m_high_a, m_div_p, m_high_p;
    logic m_clk, m_ps, m_pend, m_err;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_wave.delete();
        m_div_a  = 2; m_high_a = 1;
        m_div_p  = 2; m_high_p = 1;
        m_clk    = 1'b0; m_ps = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic ld, input int dv, input int hi);
        m_ps = 1'b0;
        if (en) begin
            if (m_wave.size() == 0) begin
                if (m_pend) begin
                    m_div_a  = m_div_p;
                    m_high_a = m_high_p;
                    m_pend   = 1'b0;
                end
                for (int i = 0; i < m_div_a; i++) m_wave.push_back(i < m_high_a ? 1 : 0);
                m_ps = 1'b1;
            end
            m_clk = (m_wave.pop_front() != 0);
        end
        if (ld) begin
            if (dv >= 2 && hi >= 1 && hi < dv) begin
                m_div_p  = dv;
                m_high_p = hi;
                m_pend   = 1'b1;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk_eq({tag, ".clk_div"}, 32'(bus.o_clk_div),      32'(m_clk));
        chk_eq({tag, ".pstart"},  32'(bus.o_period_start), 32'(m_ps));
        chk_eq({tag, ".pending"}, 32'(bus.o_cfg_pending),  32'(m_pend));
        chk_eq({tag, ".err"},     32'(bus.o_cfg_err),      32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input string tag, input logic en, input logic ld, input int dv, input int hi);
        bus.i_en   = en;
        bus.i_load = ld;
        bus.i_div  = W'(dv);
        bus.i_high = W'(hi);
        @(posedge i_clk);
        #1;
        model_edge(en, ld, dv, hi);
        check_outputs(tag);
        bus.i_load = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 0, 0);
    endtask

    // Async reset mid-cycle; outputs must drop before any clock edge.
    task automatic pulse_reset(input string tag);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        bus.i_en   = 1'b0;
        bus.i_load = 1'b0;
        bus.i_div  = '0;
        bus.i_high = '0;
        model_reset();
        #3;
        check_outputs("reset");
        #9;
        i_rst_n = 1'b1;

        // Reset configuration: divide-by-2, first edge starts a period.
        run("div2", 6);

        // Mid-period load of 5/2.
        step("ld5_2", 1'b1, 1'b1, 5, 2);
        run("div5", 12);

        // Illegal then legal load.
        step("ld_bad", 1'b1, 1'b1, 4, 4);
        run("div5_err", 6);
        step("ld4_1", 1'b1, 1'b1, 4, 1);
        run("div4", 10);

        // Pending 3/1, then load 6/3 exactly on the wrap edge.
        step("ld3_1", 1'b1, 1'b1, 3, 1);
        for (int i = 0; i < 16 && m_wave.size() != 0; i++) step("to_wrap", 1'b1, 1'b0, 0, 0);
        chk_eq("at_boundary", 32'(m_wave.size()), 32'd0);
        step("ld6_3_wrap", 1'b1, 1'b1, 6, 3);
        run("div3_then6", 14);

        // Enable low for 3 cycles in the high phase of 5/2.
        step("ld5_2b", 1'b1, 1'b1, 5, 2);
        for (int i = 0; i < 16 && !(m_ps == 1'b1 && m_div_a == 5); i++) step("to_p5", 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step("en_low", 1'b0, 1'b0, 0, 0);
        run("resume", 10);

        // Widest legal period.
        step("ld255", 1'b1, 1'b1, 255, 254);
        run("div255", 520);

        // Reset with 7 pending.
        step("ld7_2", 1'b1, 1'b1, 7, 2);
        step("mid", 1'b1, 1'b0, 0, 0);
        pulse_reset("rst_mid");
        run("div2_again", 6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic en, ld;
            int   dv, hi;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) begin
                dv = $urandom_range(0, 255);
                hi = $urandom_range(0, 255);
            end else begin
                dv = $urandom_range(0, 12);
                hi = $urandom_range(0, 12);
            end
            step("rand", en, ld, dv, hi);
            if ($urandom_range(0, 999) == 0) pulse_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
